// File: rtl/clk_period_meter.sv
// Measures the spacing, in clk cycles, between consecutive edges of a slow asynchronous
// signal, with stall detection and a valid/ready result port.
module clk_period_meter #(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned TIMEOUT     = 100_000_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sig_in,
   input  logic                 meas_ready,
   output logic [CNT_WIDTH-1:0] meas_half,
   output logic                 meas_valid,
   output logic                 overrun,
   output logic                 stalled,
   output logic                 sig_sync
);

   typedef enum logic [1:0] {
      SETTLE,
      ARM,
      MEASURE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SYNC_STAGES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   state_t                 state_q;

   logic sig_edge;
   logic capture;
   logic accept;

   // NOTE: every signal written here gets a value before any condition, so no latch can form.
   always_comb begin
      sig_edge = 1'b0;
      capture  = 1'b0;
      accept   = 1'b0;
      sig_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
      capture  = (state_q == MEASURE) && sig_edge;
      accept   = meas_valid && meas_ready;
   end

   assign sig_sync = sync_q[SYNC_STAGES-1];

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SETTLE;
         cnt_q      <= '0;
         meas_half  <= '0;
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
         stalled    <= 1'b0;
      end else begin
         case (state_q)
            // The synchronizer comes out of reset at 0, so a high input fakes one edge.
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= ARM;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ARM: begin
               if (sig_edge) begin
                  state_q <= MEASURE;
                  cnt_q   <= CNT_ONE;
                  stalled <= 1'b0;
               end
            end
            MEASURE: begin
               if (sig_edge) begin
                  meas_half <= cnt_q;
                  cnt_q     <= CNT_ONE;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  stalled <= 1'b1;
                  state_q <= ARM;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= SETTLE;
               cnt_q   <= '0;
            end
         endcase

         // A capture taken together with an accept replaces the result without loss.
         if (capture) begin
            meas_valid <= 1'b1;
            if (meas_valid && !meas_ready) begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            meas_valid <= 1'b0;
         end
      end
   end

   a_cnt_bounded : assert property (@(posedge clk) disable iff (rst) cnt_q <= TIMEOUT_CNT);

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed segment table, a stall/edge boundary
// sequence and randomized toggling, all checked every cycle against a time-based model.
module tb_clk_period_meter;

   localparam int CW  = 16;
   localparam int TO  = 20;
   localparam int SS  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sig_in = 1'b0;
   logic          meas_ready = 1'b0;
   logic [CW-1:0] meas_half;
   logic          meas_valid;
   logic          overrun;
   logic          stalled;
   logic          sig_sync;

   clk_period_meter #(
      .CNT_WIDTH  (CW),
      .TIMEOUT    (TO),
      .SYNC_STAGES(SS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .meas_ready(meas_ready),
      .meas_half (meas_half),
      .meas_valid(meas_valid),
      .overrun   (overrun),
      .stalled   (stalled),
      .sig_sync  (sig_sync)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: remembers sampled input levels by cycle index and the cycle of the
   // last accepted edge; intervals are plain differences of cycle numbers.
   bit hist[$];
   int m_n;
   bit m_measuring;
   int m_last;
   bit m_valid;
   int m_half;
   bit m_ovr;
   bit m_stall;

   function automatic bit lvl(input int k);
      if (k < 0 || k >= hist.size()) return 1'b0;
      return hist[k];
   endfunction

   task automatic model_step(input bit r, input bit s, input bit rd);
      bit e;
      bit cap;
      int val;
      if (r) begin
         hist.delete();
         hist.push_back(1'b0);
         m_n = 0;
         m_measuring = 0;
         m_last = 0;
         m_valid = 0;
         m_half = 0;
         m_ovr = 0;
         m_stall = 0;
         return;
      end
      m_n++;
      hist.push_back(s);
      e   = lvl(m_n - SS) ^ lvl(m_n - SS - 1);
      cap = 0;
      val = 0;
      if (m_n > SS + 1) begin
         if (!m_measuring) begin
            if (e) begin
               m_measuring = 1;
               m_last = m_n;
               m_stall = 0;
            end
         end else if (e) begin
            cap = 1;
            val = m_n - m_last;
            m_last = m_n;
         end else if (m_n - m_last == TO) begin
            m_stall = 1;
            m_measuring = 0;
         end
      end
      if (cap) begin
         if (m_valid && !rd) m_ovr = 1;
         m_valid = 1;
         m_half = val;
      end else if (m_valid && rd) begin
         m_valid = 0;
      end
   endtask

   function automatic bit model_sync();
      if (m_n == 0) return 1'b0;
      return lvl(m_n - SS + 1);
   endfunction

   task automatic tick(input bit r, input bit s, input bit rd);
      rst = r;
      sig_in = s;
      meas_ready = rd;
      @(posedge clk);
      model_step(r, s, rd);
      #1;
      check("model_valid", meas_valid, m_valid);
      check("model_half", meas_half, m_half);
      check("model_overrun", overrun, m_ovr);
      check("model_stalled", stalled, m_stall);
      check("model_sig_sync", sig_sync, model_sync());
   endtask

   typedef struct {
      bit rst;
      bit sig;
      bit rdy;
      int cycles;
      bit e_valid;
      int e_half;
      bit e_ovr;
      bit e_stall;
      bit e_sync;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit s, input bit rd, input int n,
                               input bit v, input int h, input bit o, input bit st,
                               input bit sy);
      vec_t x;
      x.rst = r; x.sig = s; x.rdy = rd; x.cycles = n;
      x.e_valid = v; x.e_half = h; x.e_ovr = o; x.e_stall = st; x.e_sync = sy;
      return x;
   endfunction

   vec_t vecs[$];

   initial begin
      // Reset with input high: false edge flushed, stall only after a real edge.
      vecs.push_back(mk(1, 1, 0,  2, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 30, 0,  0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 25, 0,  0, 0, 1, 0));
      // Divide-by-5 style toggling with the consumer always ready.
      vecs.push_back(mk(1, 0, 0,  2, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 10, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1,  5, 0,  0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  5, 0,  5, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1,  5, 0,  5, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  5, 0,  5, 0, 0, 0));
      // Period 7 with consumer stalled: overwrite sets overrun, then one accept.
      vecs.push_back(mk(0, 1, 1,  7, 0,  5, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,  7, 1,  7, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0,  7, 1,  7, 1, 0, 1));
      vecs.push_back(mk(0, 1, 1,  1, 0,  7, 1, 0, 1));
      // Silence past TIMEOUT, then edges 9 apart.
      vecs.push_back(mk(0, 1, 0, 20, 0,  7, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0,  9, 0,  7, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0,  9, 1,  9, 1, 0, 1));
      // Edge landing exactly on the TIMEOUT count wins over the stall.
      vecs.push_back(mk(0, 0, 1, 20, 0,  9, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0,  3, 1, 20, 1, 0, 1));
      // Reset mid-measurement, then SETTLE swallows the first edge.
      vecs.push_back(mk(1, 1, 0,  1, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1,  6, 0,  0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1,  6, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1,  6, 0,  6, 0, 0, 1));

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         for (int c = 0; c < vecs[i].cycles; c++) begin
            tick(vecs[i].rst, vecs[i].sig, vecs[i].rdy);
         end
         check($sformatf("vec%0d_valid", i), meas_valid, vecs[i].e_valid);
         check($sformatf("vec%0d_half", i), meas_half, vecs[i].e_half);
         check($sformatf("vec%0d_overrun", i), overrun, vecs[i].e_ovr);
         check($sformatf("vec%0d_stalled", i), stalled, vecs[i].e_stall);
         check($sformatf("vec%0d_sig_sync", i), sig_sync, vecs[i].e_sync);
      end

      // Spacing TIMEOUT+1: stall one cycle before the edge, which then re-arms only.
      tick(1, 0, 0);
      for (int c = 0; c < 5; c++) tick(0, 0, 0);
      for (int c = 0; c < 21; c++) tick(0, 1, 0);
      tick(0, 0, 0);
      check("late_edge_not_stalled_yet", stalled, 0);
      tick(0, 0, 0);
      check("late_edge_stalled", stalled, 1);
      tick(0, 0, 0);
      check("late_edge_rearm_stall_clear", stalled, 0);
      check("late_edge_no_result", meas_valid, 0);

      // Randomized toggling with random ready and rare resets.
      begin
         int cyc;
         bit lvl_now;
         cyc = 0;
         lvl_now = 0;
         tick(1, 0, 0);
         while (cyc < 3000) begin
            int hold;
            case ($urandom_range(0, 9))
               0:       hold = $urandom_range(19, 21);
               1:       hold = $urandom_range(22, 40);
               default: hold = $urandom_range(1, 12);
            endcase
            lvl_now = ~lvl_now;
            for (int c = 0; c < hold; c++) begin
               bit rd;
               bit r;
               rd = ($urandom_range(0, 3) != 0);
               r  = ($urandom_range(0, 499) == 0);
               tick(r, lvl_now, rd);
               cyc++;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
